mic_level_meter: RTL and testbench
==================================

// Module: mic_level_meter
// PURPOSE
//  Sits between Audio_Capture and the volume-bar/OLED stage.
//  Consumes 12-bit mic samples at the 20 kHz capture rate and tracks peak |sample - BASELINE| over a window.
//  At each window end, publishes a 4-bit volume level (0..15) with a one-cycle valid strobe.
//  Also drives a decaying peak-hold level and a 16-bit LED bar, so vol_bar and the LED mux take a clean level.
// PARAMETERS
//  WINDOW        4000   samples per measurement window (4000 @ 20 kHz = 200 ms); >= 2
//  BASELINE      2048   mic DC midpoint, 12-bit unsigned
//  HOLD_WINDOWS  5      windows peak_hold is frozen after a new peak before decay starts
// PORTS
//  clk          in   1   100 MHz system clock
//  reset        in   1   asynchronous, active-high reset
//  sample_clk   in   1   raw 20 kHz square wave (same clock as Audio_Capture cs); asynchronous to logic
//  mic_in       in   12  unsigned sample from Audio_Capture
//  level        out  4   quantised window peak, 0..15
//  level_valid  out  1   1-clk pulse when level/peak_raw/peak_hold update
//  peak_raw     out  11  saturated window peak magnitude, 0..2047
//  peak_hold    out  4   peak-hold level with decay
//  led          out  16  bar display of level plus peak-hold marker
// BEHAVIOUR
//  Reset (async assert, sync release) forces all outputs to 0 and clears internal state.
//  - Internal state: sync FFs, sample counter, running max, hold counter.
//  Tick detection
//  - sample_clk passes through a 2-FF synchroniser, then a rising-edge detect register.
//  - The one-clk tick pulse fires 3 clk after the raw rising edge; mic_in is captured only on tick cycles.
//  Magnitude
//  - mag = (mic_in >= BASELINE) ? mic_in - BASELINE : BASELINE - mic_in.
//  - Computed 12-bit, then saturated to 11 bits: 2048 -> 2047.
//  Accumulation
//  - On each tick: run_max <= max(run_max, mag); cnt <= cnt + 1.
//  - When cnt == WINDOW-1 on a tick, that sample closes the window. The next clk does all of:
//    - peak_raw <= max(run_max, mag);
//    - level <= that value [10:7] (128 counts per level);
//    - level_valid = 1 for exactly one clk;
//    - run_max and cnt are cleared to 0.
//  - Latency: raw edge of the closing sample -> level_valid = 4 clk.
//  - Between window ends, level, peak_raw and peak_hold hold their values.
//  Peak hold, evaluated on the level_valid cycle using the new level L:
//  - L >= peak_hold: peak_hold <= L; hold_cnt <= HOLD_WINDOWS.
//  - else if hold_cnt != 0: hold_cnt <= hold_cnt - 1; peak_hold unchanged.
//  - else: peak_hold <= max(peak_hold - 1, L). Never underflows below 0.
//  LED map, registered and updated on the same clk as level
//  - led[i] = (i < level) | (peak_hold != 0 && i == peak_hold - 1).
//  - led[15] is never lit.
//  Boundaries
//  - Ticks arriving faster than 1 per 3 clk are undefined. The 20 kHz rate leaves 5000 clk of margin.
//  - Reset mid-window discards the partial window. The first post-reset window starts at cnt 0.
//  - mic_in == BASELINE gives mag 0. Both mic_in = 0 and mic_in = 4095 reach level 15.
// TESTING  (bench may override WINDOW=8 for speed; values below hold for any WINDOW)
//  1 Full window with mic_in = 2048 -> one level_valid pulse 4 clk after closing edge; level 0, peak_raw 0, led 16'h0000.
//  2 Window of 2048 with one 4095 sample -> peak_raw 2047, level 15, peak_hold 15, led 16'h7FFF.
//  3 Window containing mic_in = 0 -> mag saturates; peak_raw 2047, level 15 (no wrap to 0).
//  4 Window peak mic_in = 2688 (mag 640) from reset -> level 5, peak_hold 5, led 16'h001F.
//  5 One level-15 window, then level-0 windows:
//    - peak_hold is 15 for the next 5 windows, then 14, 13, ... one step per window, reaching 0;
//    - led = single bit at peak_hold-1.
//  6 Assert reset after WINDOW/2 samples of 4095 -> all outputs 0 at once. Next full window of 2048 -> level 0.

Source files
------------

// File: rtl/mic_level_meter.sv
// Windowed microphone level meter: finds the peak deviation from the DC baseline
// over each window of samples and publishes a 4-bit level, a decaying peak hold and an LED bar.
module mic_level_meter #(
  parameter int WINDOW       = 4000,
  parameter int BASELINE     = 2048,
  parameter int HOLD_WINDOWS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_clk,
  input  logic [11:0] mic_in,
  output logic [3:0]  level,
  output logic        level_valid,
  output logic [10:0] peak_raw,
  output logic [3:0]  peak_hold,
  output logic [15:0] led
);

  localparam int CNT_W  = $clog2(WINDOW);
  localparam int HOLD_W = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
  localparam logic [11:0]       BASE      = 12'(BASELINE);
  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(WINDOW - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_WINDOWS);

  logic              rst_meta, rst;
  logic [2:0]        sclk_sync;
  logic              tick;
  logic [CNT_W-1:0]  cnt;
  logic [10:0]       run_max;
  logic [HOLD_W-1:0] hold_cnt;

  logic [11:0]       mag_wide;
  logic [10:0]       mag, win_peak;
  logic [3:0]        new_level, ph_next;
  logic [HOLD_W-1:0] hold_next;
  logic [15:0]       led_next;

  // NOTE: reset asserts asynchronously but releases on a clock edge so no flop sees
  // its reset removed near an active edge; everything downstream resets from rst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {rst_meta, rst} <= 2'b11;
    else       {rst_meta, rst} <= {1'b0, rst_meta};
  end

  // Two synchroniser stages plus one history stage; tick is registered so it
  // lands three clocks after the raw rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      tick      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sample_clk};
      tick      <= sclk_sync[1] & ~sclk_sync[2];
    end
  end

  always_comb begin
    mag_wide  = (mic_in >= BASE) ? (mic_in - BASE) : (BASE - mic_in);
    mag       = mag_wide[11] ? 11'h7FF : mag_wide[10:0];
    win_peak  = (mag > run_max) ? mag : run_max;
    new_level = win_peak[10:7];

    ph_next   = peak_hold;
    hold_next = hold_cnt;
    if (new_level >= peak_hold) begin
      ph_next   = new_level;
      hold_next = HOLD_INIT;
    end else if (hold_cnt != '0) begin
      hold_next = hold_cnt - HOLD_W'(1);
    end else begin
      // new_level < peak_hold here, so max(peak_hold-1, new_level) is peak_hold-1.
      ph_next = peak_hold - 4'd1;
    end

    led_next = '0;
    for (int i = 0; i < 16; i++)
      led_next[i] = (i < int'(new_level)) || ((ph_next != '0) && (i == int'(ph_next) - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      run_max     <= '0;
      hold_cnt    <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      peak_raw    <= '0;
      peak_hold   <= '0;
      led         <= '0;
    end else begin
      level_valid <= 1'b0;
      if (tick) begin
        if (cnt == LAST) begin
          peak_raw    <= win_peak;
          level       <= new_level;
          level_valid <= 1'b1;
          peak_hold   <= ph_next;
          hold_cnt    <= hold_next;
          led         <= led_next;
          run_max     <= '0;
          cnt         <= '0;
        end else begin
          run_max <= win_peak;
          cnt     <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mic_level_meter.sv
// Self-checking bench for mic_level_meter: directed windows plus random windows,
// compared against a window-level arithmetic model of the meter.
module tb_mic_level_meter;

  localparam int WIN  = 8;
  localparam int HOLD = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_clk;
  logic [11:0] mic_in;
  logic [3:0]  level;
  logic        level_valid;
  logic [10:0] peak_raw;
  logic [3:0]  peak_hold;
  logic [15:0] led;

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  // Reference model state
  int m_cnt, m_max, m_level, m_peak_raw, m_ph, m_hold, m_led;

  mic_level_meter #(.WINDOW(WIN), .BASELINE(2048), .HOLD_WINDOWS(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_clk  (sample_clk),
    .mic_in      (mic_in),
    .level       (level),
    .level_valid (level_valid),
    .peak_raw    (peak_raw),
    .peak_hold   (peak_hold),
    .led         (led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (level_valid === 1'b1) vcount++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_max = 0; m_level = 0; m_peak_raw = 0;
    m_ph = 0; m_hold = 0; m_led = 0;
  endtask

  task automatic model_sample(input int v, output bit closed);
    int mag;
    mag = (v >= 2048) ? v - 2048 : 2048 - v;
    if (mag > 2047) mag = 2047;
    if (mag > m_max) m_max = mag;
    closed = 1'b0;
    if (m_cnt == WIN - 1) begin
      closed     = 1'b1;
      m_peak_raw = m_max;
      m_level    = m_max / 128;
      if (m_level >= m_ph) begin
        m_ph   = m_level;
        m_hold = HOLD;
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        m_ph = (m_ph - 1 > m_level) ? m_ph - 1 : m_level;
      end
      m_led = ((1 << m_level) - 1) | ((m_ph > 0) ? (1 << (m_ph - 1)) : 0);
      m_max = 0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"},     32'(level),       32'd0);
    check({tag, "_valid"},     32'(level_valid), 32'd0);
    check({tag, "_peak_raw"},  32'(peak_raw),    32'd0);
    check({tag, "_peak_hold"}, 32'(peak_hold),   32'd0);
    check({tag, "_led"},       32'(led),         32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero(tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    model_reset();
  endtask

  // One sample period: raw edge mid-cycle, then watch up to 8 clocks for the strobe.
  task automatic send(input logic [11:0] v);
    bit closed;
    int lat, vc0;
    vc0    = vcount;
    mic_in = v;
    @(negedge clk);
    sample_clk = 1'b1;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (level_valid === 1'b1 && lat < 0) lat = k;
    end
    @(negedge clk);
    sample_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    model_sample(int'(v), closed);
    if (closed) begin
      check("latency",   32'(lat),          32'd4);
      check("pulses",    32'(vcount - vc0), 32'd1);
      check("level",     32'(level),        32'(m_level));
      check("peak_raw",  32'(peak_raw),     32'(m_peak_raw));
      check("peak_hold", 32'(peak_hold),    32'(m_ph));
      check("led",       32'(led),          32'(m_led));
    end else begin
      check("no_pulse",   32'(vcount - vc0), 32'd0);
      check("level_hold", 32'(level),        32'(m_level));
    end
  endtask

  task automatic window(input logic [11:0] fill, input int idx, input logic [11:0] sv);
    for (int i = 0; i < WIN; i++) send((i == idx) ? sv : fill);
  endtask

  initial begin
    int exp_ph, lim, d, v;
    reset      = 1'b1;
    sample_clk = 1'b0;
    mic_in     = 12'd2048;
    model_reset();
    do_reset("reset");

    // Quiet window, then a single full-scale sample, then a zero sample
    window(12'd2048, -1, 12'd0);
    check("quiet_level", 32'(level), 32'd0);
    check("quiet_led",   32'(led),   32'h0000);
    window(12'd2048, 3, 12'd4095);
    check("max_peak_raw", 32'(peak_raw),  32'd2047);
    check("max_level",    32'(level),     32'd15);
    check("max_hold",     32'(peak_hold), 32'd15);
    check("max_led",      32'(led),       32'h7FFF);
    window(12'd2048, 5, 12'd0);
    check("zero_peak_raw", 32'(peak_raw), 32'd2047);
    check("zero_level",    32'(level),    32'd15);

    // Mid-scale peak from reset
    do_reset("reset2");
    window(12'd2048, 2, 12'd2688);
    check("mid_level", 32'(level),     32'd5);
    check("mid_hold",  32'(peak_hold), 32'd5);
    check("mid_led",   32'(led),       32'h001F);

    // Peak-hold freeze and decay
    do_reset("reset3");
    window(12'd2048, 0, 12'd4095);
    for (int k = 1; k <= 21; k++) begin
      window(12'd2048, -1, 12'd0);
      exp_ph = (k <= HOLD) ? 15 : ((15 - (k - HOLD) < 0) ? 0 : 15 - (k - HOLD));
      check("decay_hold", 32'(peak_hold), 32'(exp_ph));
      check("decay_led",  32'(led), (exp_ph > 0) ? (32'd1 << (exp_ph - 1)) : 32'd0);
    end

    // Reset in the middle of a loud window
    window(12'd2048, 1, 12'd4095);
    for (int i = 0; i < WIN / 2; i++) send(12'd4095);
    do_reset("midreset");
    window(12'd2048, -1, 12'd0);
    check("post_reset_level",    32'(level),    32'd0);
    check("post_reset_peak_raw", 32'(peak_raw), 32'd0);

    // Random windows with varying amplitude
    for (int w = 0; w < 14; w++) begin
      case ($urandom_range(0, 4))
        0: lim = 100;
        1: lim = 400;
        2: lim = 900;
        3: lim = 1500;
        default: lim = 2048;
      endcase
      for (int i = 0; i < WIN; i++) begin
        d = int'($urandom_range(0, lim));
        v = ($urandom_range(0, 1) == 1) ? 2048 + d : 2048 - d;
        if (v > 4095) v = 4095;
        if (v < 0) v = 0;
        send(12'(v));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
